// File: rtl/rs_issue_pkg.sv
// Shared types and widths for the reservation-station issue arbiter.
package rs_issue_pkg;

  localparam int RS_DATA_W = 64;
  localparam int RS_CMD_W  = 10;

  // Tag width depends on the ROB size, so the full packet type is
  // completed inside the arbiter around this fixed-width body.
  typedef struct packed {
    logic [RS_CMD_W-1:0]  commands;
    logic [RS_DATA_W-1:0] val1;
    logic [RS_DATA_W-1:0] val2;
  } issue_body_t;

endpackage

// File: rtl/rs_issue_arbiter_picker.sv
// Round-robin priority picker: first requester at or above ptr, with wrap.
module rr_priority_picker #(
  parameter  int NUM_RS = 4,
  localparam int IDX_W  = $clog2(NUM_RS)
) (
  input  logic [NUM_RS-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_RS-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o
);

  always_comb begin
    logic             found;
    logic [IDX_W-1:0] k;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    k           = '0;
    for (int i = 0; i < NUM_RS; i++) begin
      k = IDX_W'((int'(ptr_i) + i) % NUM_RS);
      if (!found && req_i[k]) begin
        found       = 1'b1;
        grant_o[k]  = 1'b1;
        grant_idx_o = k;
      end
    end
  end

endmodule

// File: rtl/rs_issue_arbiter.sv
// Issue select: round-robin grant over ready stations into a registered
// execute-input slot that holds under execute back-pressure.
module rs_issue_arbiter
  import rs_issue_pkg::*;
#(
  parameter  int NUM_RS     = 4,
  parameter  int ROBsize    = 16,
  parameter  int ROBsizeLog = $clog2(ROBsize + 1),
  localparam int IDX_W      = $clog2(NUM_RS)
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         flush_i,
  input  logic [NUM_RS-1:0]            rsReady_i,
  input  logic [NUM_RS*RS_DATA_W-1:0]  rsVal1_i,
  input  logic [NUM_RS*RS_DATA_W-1:0]  rsVal2_i,
  input  logic [NUM_RS*RS_CMD_W-1:0]   rsCommands_i,
  input  logic [NUM_RS*ROBsizeLog-1:0] rsTag_i,
  input  logic                         execStall_i,
  output logic [NUM_RS-1:0]            rsStall_o,
  output logic                         execValid_o,
  output logic [RS_DATA_W-1:0]         execVal1_o,
  output logic [RS_DATA_W-1:0]         execVal2_o,
  output logic [RS_CMD_W-1:0]          execCommands_o,
  output logic [ROBsizeLog-1:0]        execTag_o,
  output logic [IDX_W-1:0]             grantIdx_o
);

  typedef struct packed {
    logic [ROBsizeLog-1:0] tag;
    issue_body_t           body;
  } issue_pkt_t;

  logic              hold;
  logic              accept;
  logic              any_grant;
  logic [NUM_RS-1:0] grant;
  logic [IDX_W-1:0]  grant_idx;
  issue_pkt_t        sel_pkt;

  logic              vld_p1_q, vld_p1_d;
  issue_pkt_t        pkt_p1_q, pkt_p1_d;
  logic [IDX_W-1:0]  idx_p1_q, idx_p1_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;

  rr_priority_picker #(.NUM_RS(NUM_RS)) u_picker (
    .req_i       (rsReady_i),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx)
  );

  assign any_grant = |grant;
  assign hold      = vld_p1_q & execStall_i;
  // A bubble never holds, so a stalled-but-empty slot still accepts.
  assign accept    = ~hold & ~flush_i & reset_i;

  // Stations drain on the same edge they see stall low, so the stall
  // vector must exactly match what the slot captures below.
  assign rsStall_o = ~({NUM_RS{accept}} & grant);

  // Grant is one-hot, so an AND-OR mux selects the issuing station.
  always_comb begin
    sel_pkt = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      if (grant[k]) begin
        sel_pkt.tag           |= rsTag_i[k*ROBsizeLog +: ROBsizeLog];
        sel_pkt.body.commands |= rsCommands_i[k*RS_CMD_W +: RS_CMD_W];
        sel_pkt.body.val1     |= rsVal1_i[k*RS_DATA_W +: RS_DATA_W];
        sel_pkt.body.val2     |= rsVal2_i[k*RS_DATA_W +: RS_DATA_W];
      end
    end
  end

  // Flush beats hold; with no grant the payload keeps its old value.
  always_comb begin
    vld_p1_d = vld_p1_q;
    pkt_p1_d = pkt_p1_q;
    idx_p1_d = idx_p1_q;
    ptr_d    = ptr_q;
    if (flush_i) begin
      vld_p1_d = 1'b0;
      ptr_d    = '0;
    end else if (accept) begin
      vld_p1_d = any_grant;
      if (any_grant) begin
        pkt_p1_d = sel_pkt;
        idx_p1_d = grant_idx;
        ptr_d    = (grant_idx == IDX_W'(NUM_RS - 1)) ? '0 : grant_idx + 1'b1;
      end
    end
  end

  // Stage p1: execute-input slot and round-robin pointer
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      vld_p1_q <= 1'b0;
      pkt_p1_q <= '0;
      idx_p1_q <= '0;
      ptr_q    <= '0;
    end else begin
      vld_p1_q <= vld_p1_d;
      pkt_p1_q <= pkt_p1_d;
      idx_p1_q <= idx_p1_d;
      ptr_q    <= ptr_d;
    end
  end

  assign execValid_o    = vld_p1_q;
  assign execVal1_o     = pkt_p1_q.body.val1;
  assign execVal2_o     = pkt_p1_q.body.val2;
  assign execCommands_o = pkt_p1_q.body.commands;
  assign execTag_o      = pkt_p1_q.tag;
  assign grantIdx_o     = idx_p1_q;

endmodule

// File: tb/tb_rs_issue_arbiter.sv
// Randomized and directed bench for rs_issue_arbiter against a behavioural model.
module tb_rs_issue_arbiter;

  localparam int NUM_RS = 4;
  localparam int ROBsize = 16;
  localparam int TW = $clog2(ROBsize + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic estall = 1'b0;
  logic [NUM_RS-1:0] rdy = '0;
  logic [NUM_RS*64-1:0] v1_bus, v2_bus;
  logic [NUM_RS*10-1:0] cmd_bus;
  logic [NUM_RS*TW-1:0] tag_bus;

  logic [63:0]   st_v1 [NUM_RS];
  logic [63:0]   st_v2 [NUM_RS];
  logic [9:0]    st_cmd[NUM_RS];
  logic [TW-1:0] st_tag[NUM_RS];

  logic [NUM_RS-1:0] stall_o;
  logic              ev;
  logic [63:0]       e1, e2;
  logic [9:0]        ec;
  logic [TW-1:0]     et;
  logic [1:0]        gi;

  // Behavioural model of the execute slot and round-robin pointer
  bit          m_valid;
  logic [63:0] m_v1, m_v2;
  logic [9:0]  m_cmd;
  logic [TW-1:0] m_tag;
  int          m_idx, m_ptr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always_comb begin
    v1_bus = '0; v2_bus = '0; cmd_bus = '0; tag_bus = '0;
    for (int k = 0; k < NUM_RS; k++) begin
      v1_bus[k*64 +: 64]  = st_v1[k];
      v2_bus[k*64 +: 64]  = st_v2[k];
      cmd_bus[k*10 +: 10] = st_cmd[k];
      tag_bus[k*TW +: TW] = st_tag[k];
    end
  end

  rs_issue_arbiter #(.NUM_RS(NUM_RS), .ROBsize(ROBsize)) dut (
    .clk_i          (clk),
    .reset_i        (rst_n),
    .flush_i        (flush),
    .rsReady_i      (rdy),
    .rsVal1_i       (v1_bus),
    .rsVal2_i       (v2_bus),
    .rsCommands_i   (cmd_bus),
    .rsTag_i        (tag_bus),
    .execStall_i    (estall),
    .rsStall_o      (stall_o),
    .execValid_o    (ev),
    .execVal1_o     (e1),
    .execVal2_o     (e2),
    .execCommands_o (ec),
    .execTag_o      (et),
    .grantIdx_o     (gi)
  );

  function automatic void model_reset();
    m_valid = 0; m_v1 = '0; m_v2 = '0; m_cmd = '0; m_tag = '0; m_idx = 0; m_ptr = 0;
  endfunction

  function automatic int pick();
    for (int i = 0; i < NUM_RS; i++) begin
      int k;
      k = (m_ptr + i) % NUM_RS;
      if (rdy[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit model_accept();
    return rst_n && !flush && !(m_valid && estall);
  endfunction

  function automatic logic [NUM_RS-1:0] exp_stall();
    logic [NUM_RS-1:0] s;
    int g;
    s = '1;
    g = pick();
    if (model_accept() && g >= 0) s[g] = 1'b0;
    return s;
  endfunction

  task automatic tick();
    int g;
    bit acc;
    g = pick();
    acc = model_accept();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (flush) begin
      m_valid = 0; m_ptr = 0;
    end else if (acc) begin
      m_valid = (g >= 0);
      if (g >= 0) begin
        m_v1 = st_v1[g]; m_v2 = st_v2[g]; m_cmd = st_cmd[g]; m_tag = st_tag[g];
        m_idx = g; m_ptr = (g + 1) % NUM_RS;
      end
    end
    #1;
  endtask

  task automatic randomize_stations();
    for (int k = 0; k < NUM_RS; k++) begin
      st_v1[k]  = {$urandom, $urandom};
      st_v2[k]  = {$urandom, $urandom};
      st_cmd[k] = 10'($urandom);
      st_tag[k] = TW'($urandom_range(1, ROBsize));
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ev !== 1'b0 || et !== '0 || e1 !== '0 || e2 !== '0 || ec !== '0 || gi !== '0) begin
      errors++; $display("FAIL reset_init ev=%b tag=%0d v1=%h v2=%h cmd=%0d gi=%0d required all 0", ev, et, e1, e2, ec, gi);
    end
    checks++; if (stall_o !== 4'b1111) begin
      errors++; $display("FAIL reset_init_stall got %b required 1111", stall_o);
    end
    @(negedge clk);
    rst_n = 1'b1; rdy = 4'b0001; estall = 1'b0;
    tick();
    checks++; if (ev !== 1'b1 || et !== st_tag[0]) begin
      errors++; $display("FAIL reset_prefill ev=%b tag=%0d required 1/%0d", ev, et, st_tag[0]);
    end
    #2; rst_n = 1'b0; model_reset(); #1;
    checks++; if (ev !== 1'b0 || et !== '0 || stall_o !== 4'b1111) begin
      errors++; $display("FAIL reset_async ev=%b tag=%0d stall=%b required 0/0/1111", ev, et, stall_o);
    end
    @(negedge clk);
    rst_n = 1'b1; rdy = '0;
  endtask

  task automatic test_single_issue();
    @(negedge clk);
    estall = 0; flush = 0; rdy = 4'b0100;
    st_tag[2] = TW'(3); st_v1[2] = 64'hA; st_v2[2] = 64'hB; st_cmd[2] = 10'd10;
    #1;
    checks++; if (stall_o !== 4'b1011) begin
      errors++; $display("FAIL single_stall got %b required 1011", stall_o);
    end
    tick();
    checks++; if (ev !== 1'b1 || et !== TW'(3) || e1 !== 64'hA || e2 !== 64'hB || ec !== 10'd10 || gi !== 2'd2) begin
      errors++; $display("FAIL single_slot ev=%b tag=%0d v1=%h v2=%h cmd=%0d gi=%0d required 1/3/a/b/10/2", ev, et, e1, e2, ec, gi);
    end
    @(negedge clk);
    rdy = 4'b1111; #1;
    checks++; if (stall_o !== 4'b0111) begin
      errors++; $display("FAIL single_ptr_next got %b required 0111", stall_o);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_s [5];
    int exp_g [5];
    exp_s = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    exp_g = '{0, 1, 2, 3, 0};
    @(negedge clk);
    rst_n = 1'b0; model_reset();
    @(negedge clk);
    rst_n = 1'b1; rdy = 4'b1111; estall = 0; flush = 0;
    for (int c = 0; c < 5; c++) begin
      if (c != 0) @(negedge clk);
      randomize_stations();
      #1;
      checks++; if (stall_o !== exp_s[c]) begin
        errors++; $display("FAIL rr_stall cycle %0d got %b required %b", c, stall_o, exp_s[c]);
      end
      tick();
      checks++; if (ev !== 1'b1 || gi !== 2'(exp_g[c]) || et !== st_tag[exp_g[c]]) begin
        errors++; $display("FAIL rr_grant cycle %0d ev=%b gi=%0d tag=%0d required 1/%0d/%0d", c, ev, gi, et, exp_g[c], st_tag[exp_g[c]]);
      end
    end
  endtask

  task automatic test_back_pressure();
    @(negedge clk);
    rdy = 4'b0001; estall = 0; st_tag[0] = TW'(5);
    tick();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      estall = 1; rdy = 4'b1111; randomize_stations(); #1;
      checks++; if (stall_o !== 4'b1111) begin
        errors++; $display("FAIL bp_stall cycle %0d got %b required 1111", c, stall_o);
      end
      tick();
      checks++; if (ev !== 1'b1 || et !== TW'(5) || gi !== 2'd0) begin
        errors++; $display("FAIL bp_hold cycle %0d ev=%b tag=%0d gi=%0d required 1/5/0", c, ev, et, gi);
      end
    end
    @(negedge clk);
    estall = 0; #1;
    checks++; if (stall_o !== 4'b1101) begin
      errors++; $display("FAIL bp_release got %b required 1101", stall_o);
    end
    tick();
    checks++; if (gi !== 2'd1 || et !== st_tag[1]) begin
      errors++; $display("FAIL bp_release_slot gi=%0d tag=%0d required 1/%0d", gi, et, st_tag[1]);
    end
  endtask

  task automatic test_bubble_overwrite();
    @(negedge clk);
    rdy = '0; estall = 0;
    tick();
    checks++; if (ev !== 1'b0) begin
      errors++; $display("FAIL bubble_empty ev=%b required 0", ev);
    end
    @(negedge clk);
    estall = 1; rdy = 4'b0010; randomize_stations(); #1;
    checks++; if (stall_o !== 4'b1101) begin
      errors++; $display("FAIL bubble_stall got %b required 1101", stall_o);
    end
    tick();
    checks++; if (ev !== 1'b1 || gi !== 2'd1 || et !== st_tag[1] || e1 !== st_v1[1]) begin
      errors++; $display("FAIL bubble_load ev=%b gi=%0d tag=%0d required 1/1/%0d", ev, gi, et, st_tag[1]);
    end
  endtask

  task automatic test_flush_during_hold();
    @(negedge clk);
    estall = 0; rdy = 4'b0100;
    tick();
    @(negedge clk);
    estall = 1; flush = 1; rdy = 4'b1111; #1;
    checks++; if (stall_o !== 4'b1111) begin
      errors++; $display("FAIL flush_stall got %b required 1111", stall_o);
    end
    tick();
    checks++; if (ev !== 1'b0) begin
      errors++; $display("FAIL flush_valid ev=%b required 0", ev);
    end
    @(negedge clk);
    flush = 0; #1;
    checks++; if (stall_o !== 4'b1110) begin
      errors++; $display("FAIL flush_regrant_stall got %b required 1110", stall_o);
    end
    tick();
    checks++; if (ev !== 1'b1 || gi !== 2'd0) begin
      errors++; $display("FAIL flush_regrant ev=%b gi=%0d required 1/0", ev, gi);
    end
    estall = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rdy = 4'($urandom);
      estall = ($urandom_range(0, 2) == 0);
      flush = ($urandom_range(0, 15) == 0);
      randomize_stations();
      #1;
      checks++; if (stall_o !== exp_stall()) begin
        errors++; $display("FAIL rand_stall cycle %0d got %b required %b", c, stall_o, exp_stall());
      end
      tick();
      checks++; if (ev !== m_valid || (m_valid && (et !== m_tag || e1 !== m_v1 || e2 !== m_v2 || ec !== m_cmd || gi !== 2'(m_idx)))) begin
        errors++; $display("FAIL rand_slot cycle %0d ev=%b tag=%0d gi=%0d required %b/%0d/%0d", c, ev, et, gi, m_valid, m_tag, m_idx);
      end
    end
    flush = 0; estall = 0;
  endtask

  initial begin
    model_reset();
    randomize_stations();
    test_reset();
    test_single_issue();
    test_round_robin();
    test_back_pressure();
    test_bubble_overwrite();
    test_flush_during_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
